onehot_encoder_4to2: RTL and testbench

//  Registered 4-to-2 encoder: the inverse of the team's 2-4 decoder. Converts a 4-bit
//  one-hot word back to a 2-bit index, with a valid/ready handshake. Flags and counts

---
 rtl/onehot_encoder_4to2_if.sv | 58 +++++
 rtl/onehot_encoder_4to2.sv | 194 +++++++++++++++++++
 tb/tb_onehot_encoder_4to2.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_encoder_4to2_if.sv
// ---------------------------------------------------------------------------
// onehot_encoder_4to2_if
// Bundles the input handshake, the output handshake, the result fields and
// the error-counter controls of the one-hot to index encoder.
//
//   in_valid   master->slave  a word is present on y
//   in_ready   slave->master  encoder can accept a word this cycle
//   y          master->slave  4-bit word to encode (one-hot expected)
//   out_valid  slave->master  result present on x and the flags
//   out_ready  master->slave  downstream takes the result this cycle
//   x          slave->master  encoded 2-bit index
//   zero_hot   slave->master  accepted word was all zeros
//   multi_hot  slave->master  accepted word had two or more bits set
//   err_clr    master->slave  synchronous clear of err_count
//   err_count  slave->master  saturating count of bad accepted words
// ---------------------------------------------------------------------------
interface onehot_encoder_4to2_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           y;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           x;
    logic                 zero_hot;
    logic                 multi_hot;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_count;

    // Producer / consumer side that drives words and takes results.
    modport master (
        output in_valid,
        output y,
        output out_ready,
        output err_clr,
        input  in_ready,
        input  out_valid,
        input  x,
        input  zero_hot,
        input  multi_hot,
        input  err_count
    );

    // Encoder side.
    modport slave (
        input  in_valid,
        input  y,
        input  out_ready,
        input  err_clr,
        output in_ready,
        output out_valid,
        output x,
        output zero_hot,
        output multi_hot,
        output err_count
    );
endinterface

// File: rtl/onehot_encoder_4to2.sv
// ---------------------------------------------------------------------------
// onehot_encoder_4to2
// Registered 4-to-2 encoder. Converts a 4-bit one-hot word into its 2-bit
// index through a single output register with a valid/ready handshake.
// Zero-hot and multi-hot words are flagged and counted in a saturating
// error counter. Latency is one cycle; full throughput with out_ready high.
//
// Parameters
//   MSB_PRIORITY  1: highest set bit wins on a multi-hot word, 0: lowest
//   ERR_CNT_W     width of the saturating error counter (2 or more)
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    slave side of onehot_encoder_4to2_if (handshake, y, x, flags,
//          err_clr, err_count)
// ---------------------------------------------------------------------------
module onehot_encoder_4to2 #(
    parameter bit MSB_PRIORITY = 1'b1,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    onehot_encoder_4to2_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       zero_hot;
        logic       multi_hot;
    } enc_t;

    localparam logic [ERR_CNT_W-1:0] ERR_ZERO = {ERR_CNT_W{1'b0}};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Number of set bits in a 4-bit word.
    function automatic logic [2:0] count_ones(input logic [3:0] w);
        logic [2:0] n;
        n = {2'b00, w[0]} + {2'b00, w[1]} + {2'b00, w[2]} + {2'b00, w[3]};
        return n;
    endfunction

    // Index of the highest set bit; 0 for an all-zero word.
    function automatic logic [1:0] msb_index(input logic [3:0] w);
        logic [1:0] idx;
        if (w[3]) begin
            idx = 2'd3;
        end else if (w[2]) begin
            idx = 2'd2;
        end else if (w[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // Index of the lowest set bit; 0 for an all-zero word.
    function automatic logic [1:0] lsb_index(input logic [3:0] w);
        logic [1:0] idx;
        if (w[0]) begin
            idx = 2'd0;
        end else if (w[1]) begin
            idx = 2'd1;
        end else if (w[2]) begin
            idx = 2'd2;
        end else if (w[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // Full encode of one word: index plus zero/multi-hot classification.
    function automatic enc_t encode_word(input logic [3:0] w, input logic msb_first);
        enc_t       r;
        logic [2:0] ones;
        ones        = count_ones(w);
        r.zero_hot  = (ones == 3'd0);
        r.multi_hot = (ones >= 3'd2);
        if (msb_first) begin
            r.idx = msb_index(w);
        end else begin
            r.idx = lsb_index(w);
        end
        return r;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic                 out_valid_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 transfer_s;
    enc_t                 enc_s;
    logic                 err_word_s;
    logic [1:0]           x_r;
    logic                 zero_hot_r;
    logic                 multi_hot_r;
    logic [ERR_CNT_W-1:0] err_count_r;

    // State register of the output slot (EMPTY / FULL).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic of the output slot.
    always_comb begin
        state_next_s = ST_EMPTY;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Accept while FULL implies a transfer, so the slot reloads.
                if (transfer_s && !accept_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Output decode of the slot state and handshake qualifiers.
    always_comb begin
        out_valid_s = 1'b0;
        case (state_r)
            ST_EMPTY: out_valid_s = 1'b0;
            ST_FULL:  out_valid_s = 1'b1;
            default:  out_valid_s = 1'b0;
        endcase
        // Ready depends only on the slot and out_ready, never on y.
        in_ready_s = !out_valid_s || bus.out_ready;
        accept_s   = bus.in_valid && in_ready_s;
        transfer_s = out_valid_s && bus.out_ready;
    end

    // Combinational encode of the incoming word.
    always_comb begin
        enc_s      = encode_word(bus.y, MSB_PRIORITY);
        err_word_s = enc_s.zero_hot || enc_s.multi_hot;
    end

    // Result register: loads on accept, otherwise holds so x is stable under back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r         <= 2'd0;
            zero_hot_r  <= 1'b0;
            multi_hot_r <= 1'b0;
        end else if (accept_s) begin
            x_r         <= enc_s.idx;
            zero_hot_r  <= enc_s.zero_hot;
            multi_hot_r <= enc_s.multi_hot;
        end
    end

    // Saturating error counter; clear has priority over an increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_r <= ERR_ZERO;
        end else if (bus.err_clr) begin
            err_count_r <= ERR_ZERO;
        end else if (accept_s && err_word_s && (err_count_r != ERR_MAX)) begin
            err_count_r <= err_count_r + ERR_ONE;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.x         = x_r;
    assign bus.zero_hot  = zero_hot_r;
    assign bus.multi_hot = multi_hot_r;
    assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_onehot_encoder_4to2.sv
// ---------------------------------------------------------------------------
// tb_onehot_encoder_4to2
// Bench for onehot_encoder_4to2. Three instances share one stimulus:
//   dut_a  MSB_PRIORITY=1, ERR_CNT_W=8
//   dut_b  MSB_PRIORITY=0, ERR_CNT_W=8
//   dut_c  MSB_PRIORITY=1, ERR_CNT_W=2 (saturation)
// Expected results are queued when a word is accepted; output transfers are
// recorded by a monitor and compared in order by the scenario tasks.
// ---------------------------------------------------------------------------
module tb_onehot_encoder_4to2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] y;
    logic       out_ready;
    logic       err_clr;

    int total = 0;
    int bad   = 0;

    // Entries are {multi_hot, zero_hot, x[1:0]}.
    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    logic [3:0] obs_a[$];
    logic [3:0] obs_b[$];
    int rd_a = 0;
    int rd_b = 0;
    int err_a = 0;
    int err_c = 0;

    onehot_encoder_4to2_if #(.ERR_CNT_W(8)) bus_a ();
    onehot_encoder_4to2_if #(.ERR_CNT_W(8)) bus_b ();
    onehot_encoder_4to2_if #(.ERR_CNT_W(2)) bus_c ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.y         = y;
    assign bus_a.out_ready = out_ready;
    assign bus_a.err_clr   = err_clr;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.y         = y;
    assign bus_b.out_ready = out_ready;
    assign bus_b.err_clr   = err_clr;
    assign bus_c.in_valid  = in_valid;
    assign bus_c.y         = y;
    assign bus_c.out_ready = out_ready;
    assign bus_c.err_clr   = err_clr;

    onehot_encoder_4to2 #(.MSB_PRIORITY(1'b1), .ERR_CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    onehot_encoder_4to2 #(.MSB_PRIORITY(1'b0), .ERR_CNT_W(8)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    onehot_encoder_4to2 #(.MSB_PRIORITY(1'b1), .ERR_CNT_W(2)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    always #5 clk = ~clk;

    // Record every output transfer, sampled half a cycle before the edge that takes it.
    always @(negedge clk) begin
        if (!reset && out_ready && bus_a.out_valid) obs_a.push_back({bus_a.multi_hot, bus_a.zero_hot, bus_a.x});
        if (!reset && out_ready && bus_b.out_valid) obs_b.push_back({bus_b.multi_hot, bus_b.zero_hot, bus_b.x});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference encoder: {multi_hot, zero_hot, index}.
    function automatic logic [3:0] model(input logic [3:0] w, input logic msb_first);
        int         n;
        logic [1:0] idx;
        n   = 0;
        idx = 2'd0;
        if (msb_first) begin
            for (int i = 0; i < 4; i++) if (w[i]) idx = 2'(i);
        end else begin
            for (int i = 3; i >= 0; i--) if (w[i]) idx = 2'(i);
        end
        for (int i = 0; i < 4; i++) n += int'(w[i]);
        return {(n >= 2), (n == 0), idx};
    endfunction

    // Present one word for one cycle; queue expectations and update error models on accept.
    task automatic drive_word(input logic [3:0] w, output bit acc);
        logic [3:0] m;
        in_valid = 1'b1;
        y        = w;
        @(negedge clk);
        acc = (bus_a.in_ready === 1'b1);
        m   = model(w, 1'b1);
        if (acc) begin
            exp_a.push_back(m);
            exp_b.push_back(model(w, 1'b0));
        end
        if (err_clr) begin
            err_a = 0;
            err_c = 0;
        end else if (acc && (m[3] || m[2])) begin
            err_a = (err_a < 255) ? err_a + 1 : 255;
            err_c = (err_c < 3) ? err_c + 1 : 3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; y = 4'd0; out_ready = 1'b1; err_clr = 1'b0;
        #20;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus_a.out_valid); end
        total++;
        if (bus_a.err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", bus_a.err_count); end
        total++;
        if (bus_a.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus_a.in_ready); end
        total++;
        if ({bus_a.multi_hot, bus_a.zero_hot, bus_a.x} !== 4'b0000) begin
            bad++; $display("FAIL reset_result got=%b want=0000", {bus_a.multi_hot, bus_a.zero_hot, bus_a.x});
        end
    endtask

    task automatic test_stream();
        bit acc;
        logic [3:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 4'b0001 << i;
            drive_word(w, acc);
            total++;
            if (!acc) begin bad++; $display("FAIL stream_accept[%0d] got=0 want=1", i); end
            total++;
            if (bus_a.out_valid !== 1'b1 || bus_a.x !== 2'(i) || bus_a.zero_hot !== 1'b0 || bus_a.multi_hot !== 1'b0) begin
                bad++; $display("FAIL stream_latency[%0d] got v=%b x=%0d zh=%b mh=%b want v=1 x=%0d zh=0 mh=0",
                                i, bus_a.out_valid, bus_a.x, bus_a.zero_hot, bus_a.multi_hot, i);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", bus_a.out_valid); end
        while (rd_a < obs_a.size()) begin
            total++;
            if (rd_a >= exp_a.size() || obs_a[rd_a] !== exp_a[rd_a]) begin
                bad++; $display("FAIL stream_sb[%0d] got=%b want=%b", rd_a, obs_a[rd_a], (rd_a < exp_a.size()) ? exp_a[rd_a] : 4'bxxxx);
            end
            rd_a++;
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL stream_count got=%0d want=%0d", obs_a.size(), exp_a.size()); end
    endtask

    task automatic test_errors();
        bit acc;
        drive_word(4'b0000, acc);
        total++;
        if (bus_a.x !== 2'd0 || bus_a.zero_hot !== 1'b1 || bus_a.multi_hot !== 1'b0) begin
            bad++; $display("FAIL zero_hot got x=%0d zh=%b mh=%b want x=0 zh=1 mh=0", bus_a.x, bus_a.zero_hot, bus_a.multi_hot);
        end
        total++;
        if (bus_a.err_count !== 8'(err_a)) begin bad++; $display("FAIL zero_hot_err got=%0d want=%0d", bus_a.err_count, err_a); end
        drive_word(4'b0110, acc);
        total++;
        if (bus_a.x !== 2'd2 || bus_a.multi_hot !== 1'b1 || bus_a.zero_hot !== 1'b0) begin
            bad++; $display("FAIL multi_msb got x=%0d mh=%b zh=%b want x=2 mh=1 zh=0", bus_a.x, bus_a.multi_hot, bus_a.zero_hot);
        end
        total++;
        if (bus_b.x !== 2'd1 || bus_b.multi_hot !== 1'b1) begin
            bad++; $display("FAIL multi_lsb got x=%0d mh=%b want x=1 mh=1", bus_b.x, bus_b.multi_hot);
        end
        total++;
        if (bus_a.err_count !== 8'(err_a)) begin bad++; $display("FAIL multi_err got=%0d want=%0d", bus_a.err_count, err_a); end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        while (rd_a < obs_a.size()) begin
            total++;
            if (rd_a >= exp_a.size() || obs_a[rd_a] !== exp_a[rd_a]) begin
                bad++; $display("FAIL errors_sb_a[%0d] got=%b want=%b", rd_a, obs_a[rd_a], (rd_a < exp_a.size()) ? exp_a[rd_a] : 4'bxxxx);
            end
            rd_a++;
        end
        while (rd_b < obs_b.size()) begin
            total++;
            if (rd_b >= exp_b.size() || obs_b[rd_b] !== exp_b[rd_b]) begin
                bad++; $display("FAIL errors_sb_b[%0d] got=%b want=%b", rd_b, obs_b[rd_b], (rd_b < exp_b.size()) ? exp_b[rd_b] : 4'bxxxx);
            end
            rd_b++;
        end
        total++;
        if (obs_b.size() != exp_b.size()) begin bad++; $display("FAIL errors_count_b got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    endtask

    task automatic test_back_pressure();
        bit acc;
        out_ready = 1'b0;
        drive_word(4'b0100, acc);
        total++;
        if (!acc) begin bad++; $display("FAIL bp_accept got=0 want=1"); end
        for (int i = 0; i < 5; i++) begin
            drive_word(4'($urandom_range(15)), acc);
            total++;
            if (acc) begin bad++; $display("FAIL bp_in_ready[%0d] got=1 want=0", i); end
            total++;
            if (bus_a.out_valid !== 1'b1 || bus_a.x !== 2'd2 || bus_a.zero_hot !== 1'b0 || bus_a.multi_hot !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b x=%0d zh=%b mh=%b want v=1 x=2 zh=0 mh=0",
                                i, bus_a.out_valid, bus_a.x, bus_a.zero_hot, bus_a.multi_hot);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", bus_a.out_valid); end
        while (rd_a < obs_a.size()) begin
            total++;
            if (rd_a >= exp_a.size() || obs_a[rd_a] !== exp_a[rd_a]) begin
                bad++; $display("FAIL bp_sb[%0d] got=%b want=%b", rd_a, obs_a[rd_a], (rd_a < exp_a.size()) ? exp_a[rd_a] : 4'bxxxx);
            end
            rd_a++;
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_a.size(), exp_a.size()); end
    endtask

    task automatic test_saturation();
        bit acc;
        for (int i = 0; i < 5; i++) drive_word(4'b0000, acc);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus_c.err_count !== 2'd3 || err_c != 3) begin bad++; $display("FAIL sat_narrow got=%0d want=3", bus_c.err_count); end
        total++;
        if (bus_a.err_count !== 8'(err_a)) begin bad++; $display("FAIL sat_wide got=%0d want=%0d", bus_a.err_count, err_a); end
        err_clr = 1'b1;
        drive_word(4'b1010, acc);
        err_clr  = 1'b0;
        in_valid = 1'b0;
        total++;
        if (bus_c.err_count !== 2'(err_c)) begin bad++; $display("FAIL clr_narrow got=%0d want=%0d", bus_c.err_count, err_c); end
        total++;
        if (bus_a.err_count !== 8'(err_a)) begin bad++; $display("FAIL clr_wide got=%0d want=%0d", bus_a.err_count, err_a); end
        @(posedge clk);
        #1;
        while (rd_a < obs_a.size()) begin
            total++;
            if (rd_a >= exp_a.size() || obs_a[rd_a] !== exp_a[rd_a]) begin
                bad++; $display("FAIL sat_sb[%0d] got=%b want=%b", rd_a, obs_a[rd_a], (rd_a < exp_a.size()) ? exp_a[rd_a] : 4'bxxxx);
            end
            rd_a++;
        end
    endtask

    task automatic test_loopback();
        bit acc;
        logic [3:0] dec;
        for (int i = 0; i < 4; i++) begin
            dec = 4'b0001 << i;  // decoder model
            drive_word(dec, acc);
            total++;
            if (bus_a.x !== 2'(i) || bus_a.zero_hot !== 1'b0 || bus_a.multi_hot !== 1'b0) begin
                bad++; $display("FAIL loop[%0d] got x=%0d zh=%b mh=%b want x=%0d zh=0 mh=0",
                                i, bus_a.x, bus_a.zero_hot, bus_a.multi_hot, i);
            end
        end
        // Reset while a result is pending: it must vanish without a transfer.
        drive_word(4'b0100, acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus_a.out_valid !== 1'b0 || bus_a.x !== 2'd0 || bus_a.err_count !== 8'd0) begin
            bad++; $display("FAIL async_reset got v=%b x=%0d err=%0d want v=0 x=0 err=0", bus_a.out_valid, bus_a.x, bus_a.err_count);
        end
        if (acc) begin
            void'(exp_a.pop_back());
            void'(exp_b.pop_back());
        end
        err_a = 0;
        err_c = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset got rdy=%b v=%b want rdy=1 v=0", bus_a.in_ready, bus_a.out_valid);
        end
        while (rd_a < obs_a.size()) begin
            total++;
            if (rd_a >= exp_a.size() || obs_a[rd_a] !== exp_a[rd_a]) begin
                bad++; $display("FAIL loop_sb_a[%0d] got=%b want=%b", rd_a, obs_a[rd_a], (rd_a < exp_a.size()) ? exp_a[rd_a] : 4'bxxxx);
            end
            rd_a++;
        end
        while (rd_b < obs_b.size()) begin
            total++;
            if (rd_b >= exp_b.size() || obs_b[rd_b] !== exp_b[rd_b]) begin
                bad++; $display("FAIL loop_sb_b[%0d] got=%b want=%b", rd_b, obs_b[rd_b], (rd_b < exp_b.size()) ? exp_b[rd_b] : 4'bxxxx);
            end
            rd_b++;
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL loop_count_a got=%0d want=%0d", obs_a.size(), exp_a.size()); end
        total++;
        if (obs_b.size() != exp_b.size()) begin bad++; $display("FAIL loop_count_b got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_errors();
        test_back_pressure();
        test_saturation();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
